// File: rtl/dcache_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_axi_bridge_pkg
// Description : Shared AXI3 encodings and the data-cache bridge state type,
//               used by the cache-side AXI bridges and their helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_axi_bridge_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    // Every beat moves one 32-bit word.
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [3:0] AXI_WSTRB_FULL = 4'hF;

    typedef enum logic [2:0] {
        DB_IDLE = 3'd0,
        DB_AR   = 3'd1,
        DB_R    = 3'd2,
        DB_AW   = 3'd3,
        DB_W    = 3'd4,
        DB_B    = 3'd5
    } dbridge_state_t;

    // Number of 32-bit words in a cache line of 2**offset_width bytes.
    function automatic int line_words(input int offset_width);
        return 1 << (offset_width - 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : axi_beat_counter
// Description : Beat counter for single-line AXI bursts. Counts accepted
//               beats, wraps modulo LINE_WORDS and flags the final beat.
// Ports       : clk        - system clock
//               rst        - asynchronous active-high reset
//               i_clear    - synchronous clear to zero (priority over inc)
//               i_inc      - advance by one beat
//               o_count    - current beat index (0 .. LINE_WORDS-1)
//               o_terminal - current index is the last beat of the line
// Revision    : 1.0 - initial release
// ============================================================================
module axi_beat_counter #(
    parameter int LINE_WORDS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic [3:0] o_count,
    output logic       o_terminal
);

    localparam logic [3:0] c_last = 4'(LINE_WORDS - 1);

    logic [3:0] r_count;
    logic       w_terminal;

    assign w_terminal = (r_count == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            // Wrap explicitly so a line shorter than 16 words never
            // produces an out-of-range index.
            r_count <= w_terminal ? 4'd0 : r_count + 4'd1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = w_terminal;

endmodule
`default_nettype wire

// File: rtl/dcache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dcache_axi_bridge
// Description : Memory-side bridge of the data cache. Turns the cache's
//               word-serial refill / write-back handshake into one-line
//               AXI3 INCR bursts and returns read beats, per-beat acks and
//               a write-back-complete pulse.
// Ports       : clk, reset                 - clock, async active-high reset
//               mem_req/mem_wen/mem_addr   - cache request (wen=1 write-back)
//               mem_wdata/wlast/awvalid    - cache write-back word stream
//               mem_rdata/mem_addr_ok      - refill data, address accepted
//               mem_data_ok/wb_ok          - beat accepted, write-back done
//               ar*/r*/aw*/w*/b*           - AXI3 master channels
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_axi_bridge
    import dcache_axi_bridge_pkg::*;
#(
    parameter int         OFFSET_WIDTH = 5,
    parameter logic [3:0] AXI_ID       = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    // cache side
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        wlast,
    input  logic        awvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_addr_ok,
    output logic        mem_data_ok,
    output logic        wb_ok,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid_o,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast_o,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int         c_line_words = line_words(OFFSET_WIDTH);
    localparam logic [3:0] c_axi_len    = 4'(c_line_words - 1);

    localparam logic [2:0] c_st_idle = DB_IDLE;
    localparam logic [2:0] c_st_ar   = DB_AR;
    localparam logic [2:0] c_st_r    = DB_R;
    localparam logic [2:0] c_st_aw   = DB_AW;
    localparam logic [2:0] c_st_w    = DB_W;
    localparam logic [2:0] c_st_b    = DB_B;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_araddr;
    logic [31:0] r_awaddr;
    logic [31:0] w_line_addr;
    logic        w_wb_req;
    logic        w_rf_req;
    logic        w_ar_hs;
    logic        w_r_beat;
    logic        w_aw_hs;
    logic        w_w_beat;
    logic        w_b_hs;
    logic [3:0]  w_beat_cnt;
    logic        w_last_beat;
    logic        w_unused;

    assign w_line_addr = {mem_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

    // Write-back outranks a simultaneous refill: the victim line must reach
    // memory before its slot is overwritten.
    assign w_wb_req = awvalid | (mem_req & mem_wen);
    assign w_rf_req = mem_req & ~mem_wen;

    assign w_ar_hs  = (r_state == c_st_ar) & arready;
    assign w_r_beat = (r_state == c_st_r)  & rvalid;
    assign w_aw_hs  = (r_state == c_st_aw) & awready;
    assign w_w_beat = (r_state == c_st_w)  & wready;
    assign w_b_hs   = (r_state == c_st_b)  & bvalid;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_wb_req) begin
                    w_state_nxt = c_st_aw;
                end else if (w_rf_req) begin
                    w_state_nxt = c_st_ar;
                end
            end
            c_st_ar: if (arready) w_state_nxt = c_st_r;
            // Leave on whichever comes first: slave's rlast or our own
            // line-length count, so a short or over-long burst cannot
            // desynchronise the cache.
            c_st_r:  if (rvalid && (rlast || w_last_beat)) w_state_nxt = c_st_idle;
            c_st_aw: if (awready) w_state_nxt = c_st_w;
            c_st_w:  if (wready && w_last_beat) w_state_nxt = c_st_b;
            c_st_b:  if (bvalid) w_state_nxt = c_st_idle;
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst addresses are captured on leaving IDLE so they stay stable
    // while the slave holds off ready, regardless of what mem_addr does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_araddr <= '0;
            r_awaddr <= '0;
        end else if (r_state == c_st_idle) begin
            if (w_wb_req) begin
                r_awaddr <= w_line_addr;
            end else if (w_rf_req) begin
                r_araddr <= w_line_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat counter, shared between the read and write bursts
    // ------------------------------------------------------------------
    axi_beat_counter #(
        .LINE_WORDS (c_line_words)
    ) u_beat_counter (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (r_state == c_st_idle),
        .i_inc      (w_r_beat | w_w_beat),
        .o_count    (w_beat_cnt),
        .o_terminal (w_last_beat)
    );

    // ------------------------------------------------------------------
    // Cache-side outputs
    // ------------------------------------------------------------------
    assign mem_addr_ok = w_ar_hs | w_aw_hs;
    assign mem_data_ok = w_r_beat | w_w_beat;
    assign mem_rdata   = w_r_beat ? rdata : 32'd0;
    assign wb_ok       = w_b_hs;

    // ------------------------------------------------------------------
    // AXI outputs
    // ------------------------------------------------------------------
    assign arid      = AXI_ID;
    assign araddr    = r_araddr;
    assign arlen     = c_axi_len;
    assign arsize    = AXI_SIZE_WORD;
    assign arburst   = AXI_BURST_INCR;
    assign arvalid   = (r_state == c_st_ar);
    assign rready    = (r_state == c_st_r);

    assign awid      = AXI_ID;
    assign awaddr    = r_awaddr;
    assign awlen     = c_axi_len;
    assign awsize    = AXI_SIZE_WORD;
    assign awburst   = AXI_BURST_INCR;
    assign awvalid_o = (r_state == c_st_aw);

    // The cache re-indexes mem_wdata off its own word offset, which moves
    // on mem_data_ok, so wdata is a straight pass-through.
    assign wid       = AXI_ID;
    assign wdata     = mem_wdata;
    assign wstrb     = AXI_WSTRB_FULL;
    assign wlast_o   = (r_state == c_st_w) & w_last_beat;
    assign wvalid    = (r_state == c_st_w);

    assign bready    = (r_state == c_st_b);

    // Response codes and IDs are deliberately ignored (no retry path).
    assign w_unused = ^{rid, rresp, bid, bresp, mem_addr[OFFSET_WIDTH-1:0], w_beat_cnt};

    // The cache's own last-word marker must agree with the bridge's count.
    a_wlast_agrees : assert property (@(posedge clk) disable iff (reset)
        w_w_beat |-> (wlast == w_last_beat));

    a_count_in_range : assert property (@(posedge clk) disable iff (reset)
        w_beat_cnt <= c_axi_len);

endmodule
`default_nettype wire

// File: tb/tb_dcache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_axi_bridge
// Description : Self-checking bench for dcache_axi_bridge. Plays both the
//               data cache and the AXI slave; expectations come from the
//               line size, the request address and the beat stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_axi_bridge;

    localparam int OW = 5;
    localparam int LW = 1 << (OW - 2);

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_wen, wlast, awvalid;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok, mem_data_ok, wb_ok;
    logic [3:0]  arid, arlen, awid, awlen, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, rready, awvalid_o, awready;
    logic        wlast_o, wvalid, wready, bready;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        rlast, rvalid, bvalid;

    int total = 0;
    int bad   = 0;
    int n_addr_ok = 0;
    int n_data_ok = 0;
    int n_wb_ok   = 0;

    always #5 clk = ~clk;

    dcache_axi_bridge #(
        .OFFSET_WIDTH (OW),
        .AXI_ID       (4'd1)
    ) dut (
        .clk (clk), .reset (reset),
        .mem_req (mem_req), .mem_wen (mem_wen), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .wlast (wlast), .awvalid (awvalid),
        .mem_rdata (mem_rdata), .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok), .wb_ok (wb_ok),
        .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize),
        .arburst (arburst), .arvalid (arvalid), .arready (arready),
        .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast),
        .rvalid (rvalid), .rready (rready),
        .awid (awid), .awaddr (awaddr), .awlen (awlen), .awsize (awsize),
        .awburst (awburst), .awvalid_o (awvalid_o), .awready (awready),
        .wid (wid), .wdata (wdata), .wstrb (wstrb), .wlast_o (wlast_o),
        .wvalid (wvalid), .wready (wready),
        .bid (bid), .bresp (bresp), .bvalid (bvalid), .bready (bready)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            n_addr_ok <= n_addr_ok + int'(mem_addr_ok);
            n_data_ok <= n_data_ok + int'(mem_data_ok);
            n_wb_ok   <= n_wb_ok + int'(wb_ok);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_req = 0; mem_wen = 0; mem_addr = '0; mem_wdata = '0; wlast = 0; awvalid = 0;
        arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    task automatic check_quiet(input string tag);
        check(tag, {arvalid, awvalid_o, wvalid, rready, bready,
                    mem_addr_ok, mem_data_ok, wb_ok, mem_rdata}, 64'd0);
    endtask

    // Refill of one line. rlast_at: beat number carrying rlast (0 = never).
    // stall_at: beat index preceded by stall_len idle cycles (-1 = none).
    task automatic do_refill(input logic [31:0] addr, input int ar_delay,
                             input int rlast_at, input int stall_at, input int stall_len);
        logic [31:0] exp_line;
        int exp_beats, a0, d0;
        exp_line  = line_of(addr);
        exp_beats = (rlast_at > 0 && rlast_at < LW) ? rlast_at : LW;
        a0 = n_addr_ok;
        d0 = n_data_ok;
        mem_req = 1; mem_wen = 0; awvalid = 0; mem_addr = addr;
        tick();
        mem_req = 0; mem_addr = $urandom();
        #1;
        check("ar_valid", {arvalid, awvalid_o, rready}, 3'b100);
        check("ar_addr", araddr, exp_line);
        check("ar_const", {arid, arlen, arsize, arburst}, {4'd1, 4'(LW - 1), 3'b010, 2'b01});
        for (int i = 0; i < ar_delay; i++) begin
            check("ar_hold", {arvalid, mem_addr_ok, araddr}, {1'b1, 1'b0, exp_line});
            tick();
        end
        arready = 1;
        #1;
        check("ar_hs", mem_addr_ok, 1'b1);
        tick();
        arready = 0;
        for (int i = 0; i < exp_beats; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    rvalid = 0; rdata = $urandom();
                    #1;
                    check("r_stall", {rready, arvalid, mem_data_ok}, 3'b100);
                    tick();
                end
            end
            rvalid = 1; rdata = $urandom(); rlast = (i == rlast_at - 1);
            rid = 4'($urandom()); rresp = 2'($urandom());
            #1;
            check("r_beat_ok", {rready, mem_data_ok}, 2'b11);
            check("r_data", mem_rdata, rdata);
            tick();
        end
        // A stray beat after the burst ends must not be taken.
        rvalid = 1; rlast = 0; rdata = $urandom();
        #1;
        check("r_after_end", {rready, mem_data_ok, mem_rdata}, 64'd0);
        tick();
        rvalid = 0;
        check("r_addr_ok_cnt", 64'(n_addr_ok - a0), 64'd1);
        check("r_beat_cnt", 64'(n_data_ok - d0), 64'(exp_beats));
    endtask

    // Write-back of one line. wmode: 0 toggling wready, 1 random, 2 always.
    // with_refill keeps a refill request pending throughout.
    // reset_beat: assert reset while presenting this W beat (0 = never).
    task automatic do_writeback(input logic [31:0] addr, input bit with_refill,
                                input int aw_delay, input int wmode,
                                input int b_delay, input int reset_beat);
        logic [31:0] line [LW];
        logic [31:0] exp_line;
        logic        wr;
        int off, cyc, a0, d0, b0;
        foreach (line[i]) line[i] = $urandom();
        exp_line = line_of(addr);
        a0 = n_addr_ok; d0 = n_data_ok; b0 = n_wb_ok;
        mem_addr = addr;
        if (with_refill) begin
            awvalid = 1; mem_req = 1; mem_wen = 0;
        end else if ($urandom_range(0, 1) == 1) begin
            awvalid = 1; mem_req = 0; mem_wen = 0;
        end else begin
            awvalid = 0; mem_req = 1; mem_wen = 1;
        end
        tick();
        awvalid = 0;
        if (!with_refill) begin
            mem_req = 0; mem_wen = 0; mem_addr = $urandom();
        end
        #1;
        check("aw_valid", {awvalid_o, arvalid, bready, wvalid}, 4'b1000);
        check("aw_addr", awaddr, exp_line);
        check("aw_const", {awid, awlen, awsize, awburst, wid, wstrb},
              {4'd1, 4'(LW - 1), 3'b010, 2'b01, 4'd1, 4'hF});
        for (int i = 0; i < aw_delay; i++) begin
            check("aw_hold", {awvalid_o, mem_addr_ok, awaddr}, {1'b1, 1'b0, exp_line});
            tick();
        end
        awready = 1;
        #1;
        check("aw_hs", mem_addr_ok, 1'b1);
        tick();
        awready = 0;
        off = 0;
        cyc = 0;
        while (off < LW && cyc < 200) begin
            if (reset_beat > 0 && off == reset_beat - 1) begin
                reset = 1;
                tick();
                check_quiet("rst_mid_w");
                check("rst_mid_w_addr", {araddr, awaddr}, 64'd0);
                idle_inputs();
                reset = 0;
                tick();
                check_quiet("rst_release");
                return;
            end
            mem_wdata = line[off];
            wlast = (off == LW - 1);
            case (wmode)
                0:       wr = (cyc % 2 == 0);
                1:       wr = 1'($urandom_range(0, 1));
                default: wr = 1'b1;
            endcase
            wready = wr;
            #1;
            check("w_data", {wvalid, bready, awvalid_o, wdata}, {3'b100, line[off]});
            check("w_last", wlast_o, (off == LW - 1));
            check("w_ok", mem_data_ok, wr);
            tick();
            if (wr) off++;
            cyc++;
        end
        wready = 0; wlast = 0;
        if (off < LW) check("w_timeout", 64'(off), 64'(LW));
        for (int i = 0; i < b_delay; i++) begin
            #1;
            check("b_wait", {bready, wb_ok, wvalid}, 3'b100);
            tick();
        end
        bvalid = 1; bresp = 2'($urandom()); bid = 4'($urandom());
        #1;
        check("b_ok", {bready, wb_ok}, 2'b11);
        tick();
        bvalid = 0;
        #1;
        // One IDLE cycle follows even when a refill is already pending.
        check("b_after", {bready, wb_ok, arvalid, awvalid_o}, 4'b0000);
        check("wb_addr_ok_cnt", 64'(n_addr_ok - a0), 64'd1);
        check("wb_beat_cnt", 64'(n_data_ok - d0), 64'(LW));
        check("wb_ok_cnt", 64'(n_wb_ok - b0), 64'd1);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        tick();
        check_quiet("rst_outputs");
        check("rst_addr", {araddr, awaddr}, 64'd0);
        reset = 0;
        tick();
        check_quiet("idle_outputs");

        // Plain refill with a two-cycle arready delay.
        do_refill(32'h8000_1234, 2, 0, -1, 0);

        // Write-back with wready toggling, B three cycles after last W.
        do_writeback(32'h0000_0F00, 1'b0, 1, 0, 3, 0);

        // Write-back and refill requested together: write-back first,
        // refill right after IDLE is re-entered.
        do_writeback($urandom(), 1'b1, $urandom_range(0, 3), 1, $urandom_range(0, 4), 0);
        do_refill($urandom(), 0, 0, -1, 0);

        // Early rlast on beat 5.
        do_refill($urandom(), $urandom_range(0, 2), 5, -1, 0);

        // Ten-cycle rvalid stall mid-burst.
        do_refill($urandom(), 0, 0, 3, 10);

        // Reset during the third W beat, then a normal refill.
        do_writeback($urandom(), 1'b0, 0, 2, 1, 3);
        do_refill($urandom(), 1, 0, -1, 0);

        // Random mix.
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_refill($urandom(), $urandom_range(0, 3), $urandom_range(0, LW + 2),
                          $urandom_range(0, 1) == 1 ? int'($urandom_range(0, LW - 1)) : -1,
                          $urandom_range(1, 4));
            end else begin
                do_writeback($urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                             $urandom_range(0, 2), $urandom_range(0, 4), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
